// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared exception bit indices, FSM states and defaults for exc_ctrl
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VEC_DEF = 32'hBFC0_0380;

    // exc_eret_type one-hot positions {int,adel,ades,sys,bp,ri,ov,eret}
    localparam logic [2:0] T_ERET = 3'd0;
    localparam logic [2:0] T_OV   = 3'd1;
    localparam logic [2:0] T_RI   = 3'd2;
    localparam logic [2:0] T_BP   = 3'd3;
    localparam logic [2:0] T_SYS  = 3'd4;
    localparam logic [2:0] T_ADES = 3'd5;
    localparam logic [2:0] T_ADEL = 3'd6;
    localparam logic [2:0] T_INT  = 3'd7;

    // wb_exc positions {adel_if,ri,ov,sys,bp,adel_d,ades}
    localparam int E_ADES    = 0;
    localparam int E_ADEL_D  = 1;
    localparam int E_BP      = 2;
    localparam int E_SYS     = 3;
    localparam int E_OV      = 4;
    localparam int E_RI      = 5;
    localparam int E_ADEL_IF = 6;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SIGNAL   = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BA_NONE  = 2'd0,
        BA_PC    = 2'd1,
        BA_DADDR = 2'd2
    } ba_sel_e;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks the highest-priority commit event as a one-hot type plus bad-address source
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic       int_happen,
    input  logic [6:0] wb_exc,
    input  logic       wb_eret,
    output logic [7:0] exc_type,
    output ba_sel_e    ba_sel
);

    logic [2:0] idx;

    // Priority: int > adel_if > ri > ov > sys > bp > adel_d > ades > eret; zero type when nothing pending
    always_comb begin
        idx = int_happen        ? T_INT  :
              wb_exc[E_ADEL_IF] ? T_ADEL :
              wb_exc[E_RI]      ? T_RI   :
              wb_exc[E_OV]      ? T_OV   :
              wb_exc[E_SYS]     ? T_SYS  :
              wb_exc[E_BP]      ? T_BP   :
              wb_exc[E_ADEL_D]  ? T_ADEL :
              wb_exc[E_ADES]    ? T_ADES : T_ERET;
        exc_type = (int_happen | (|wb_exc) | wb_eret) ? 8'b1 << idx : 8'b0;
        ba_sel = int_happen                                                  ? BA_NONE  :
                 wb_exc[E_ADEL_IF]                                           ? BA_PC    :
                 (wb_exc[E_RI] | wb_exc[E_OV] | wb_exc[E_SYS] | wb_exc[E_BP]) ? BA_NONE  :
                 (wb_exc[E_ADEL_D] | wb_exc[E_ADES])                         ? BA_DADDR : BA_NONE;
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-point exception/ERET controller driving CP0, flush and fetch redirect (optional counter: EXC_PERF_CNT_EN)
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
    parameter int          PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [PC_W-1:0] wb_pc,
    input  logic            wb_is_slot,
    input  logic [6:0]      wb_exc,
    input  logic            wb_eret,
    input  logic [PC_W-1:0] wb_daddr,
    input  logic            int_happen,
    input  logic [PC_W-1:0] cp0_epc,
    output logic            wb_kill,
    output logic [7:0]      exc_eret_type,
    output logic [PC_W-1:0] cp0_pc,
    output logic            cp0_is_slot,
    output logic [PC_W-1:0] cp0_bad_vaddr,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [31:0]     exc_count
);

    state_e          state_q, state_d;
    logic [7:0]      enc_type, type_q;
    ba_sel_e         enc_ba;
    logic [PC_W-1:0] pc_q, bad_q, rpc_q;
    logic            slot_q, ev;

    exc_prio_enc u_enc (
        .int_happen (int_happen),
        .wb_exc     (wb_exc),
        .wb_eret    (wb_eret),
        .exc_type   (enc_type),
        .ba_sel     (enc_ba)
    );

    assign ev = (state_q == S_IDLE) & wb_valid & (|enc_type);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state and state-qualified outputs; CP0 fields only visible during SIGNAL
    always_comb begin
        state_d = state_q == S_IDLE   ? (ev ? S_SIGNAL : S_IDLE) :
                  state_q == S_SIGNAL ? S_REDIRECT :
                  redirect_ready      ? S_IDLE : S_REDIRECT;
        wb_kill        = ev;
        exc_eret_type  = state_q == S_SIGNAL ? type_q : 8'b0;
        cp0_pc         = state_q == S_SIGNAL ? pc_q   : '0;
        cp0_is_slot    = state_q == S_SIGNAL & slot_q;
        cp0_bad_vaddr  = state_q == S_SIGNAL ? bad_q  : '0;
        flush          = state_q == S_SIGNAL;
        stall          = state_q != S_IDLE;
        redirect_valid = state_q == S_REDIRECT;
        redirect_pc    = state_q == S_REDIRECT ? rpc_q : '0;
    end

    // Capture the winning event at commit; EPC is sampled on the way into REDIRECT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            type_q <= '0;
            pc_q   <= '0;
            slot_q <= 1'b0;
            bad_q  <= '0;
            rpc_q  <= '0;
        end else begin
            if (ev) begin
                type_q <= enc_type;
                pc_q   <= wb_pc;
                slot_q <= wb_is_slot;
                bad_q  <= enc_ba == BA_PC ? wb_pc : enc_ba == BA_DADDR ? wb_daddr : '0;
            end
            if (state_q == S_SIGNAL) rpc_q <= type_q[T_ERET] ? cp0_epc : EXC_VEC[PC_W-1:0];
        end
    end

`ifdef EXC_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Count taken exceptions (not ERETs), once per SIGNAL cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                       cnt_q <= '0;
        else if (state_q == S_SIGNAL && !type_q[T_ERET]) cnt_q <= cnt_q + 32'd1;
    end

    assign exc_count = cnt_q;
`else
    assign exc_count = '0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        wb_is_slot = 1'b0;
    logic [6:0]  wb_exc = '0;
    logic        wb_eret = 1'b0;
    logic [31:0] wb_daddr = '0;
    logic        int_happen = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        redirect_ready = 1'b0;
    logic        wb_kill, cp0_is_slot, flush, stall, redirect_valid;
    logic [7:0]  exc_eret_type;
    logic [31:0] cp0_pc, cp0_bad_vaddr, redirect_pc, exc_count;

    int total = 0;
    int bad = 0;

    exc_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_is_slot     (wb_is_slot),
        .wb_exc         (wb_exc),
        .wb_eret        (wb_eret),
        .wb_daddr       (wb_daddr),
        .int_happen     (int_happen),
        .cp0_epc        (cp0_epc),
        .wb_kill        (wb_kill),
        .exc_eret_type  (exc_eret_type),
        .cp0_pc         (cp0_pc),
        .cp0_is_slot    (cp0_is_slot),
        .cp0_bad_vaddr  (cp0_bad_vaddr),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .exc_count      (exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_type"}, {24'd0, exc_eret_type}, 32'h0);
        chk({tag, "_flush"}, {31'd0, flush}, 32'h0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'h0);
        chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'h0);
        chk({tag, "_rpc"}, redirect_pc, 32'h0);
        chk({tag, "_cpc"}, cp0_pc, 32'h0);
        chk({tag, "_bva"}, cp0_bad_vaddr, 32'h0);
        chk({tag, "_slot"}, {31'd0, cp0_is_slot}, 32'h0);
    endtask

    initial begin
        // reset state
        tick(); tick();
        idle_outs("rst");
        chk("rst_kill", {31'd0, wb_kill}, 32'h0);
        chk("rst_cnt", exc_count, 32'h0);
        rst = 1'b1;
        tick();
        // reset asserted during SIGNAL aborts the pulse
        wb_valid = 1'b1; wb_exc = 7'b0010000; wb_pc = 32'h8000_0500;
        tick();
        wb_valid = 1'b0; wb_exc = '0;
        chk("rsig_flush", {31'd0, flush}, 32'h1);
        rst = 1'b0;
        #1;
        idle_outs("rsig");
        tick();
        rst = 1'b1;
        tick();
        idle_outs("rsig_post");
        // ov at 0x8000_1000 with redirect_ready high
        redirect_ready = 1'b1;
        wb_valid = 1'b1; wb_exc = 7'b0010000; wb_pc = 32'h8000_1000; wb_daddr = 32'h1234_5678;
        #1;
        chk("ov_kill", {31'd0, wb_kill}, 32'h1);
        tick();
        wb_valid = 1'b0; wb_exc = '0;
        chk("ov_type", {24'd0, exc_eret_type}, 32'h02);
        chk("ov_flush", {31'd0, flush}, 32'h1);
        chk("ov_stall", {31'd0, stall}, 32'h1);
        chk("ov_cpc", cp0_pc, 32'h8000_1000);
        chk("ov_bva", cp0_bad_vaddr, 32'h0);
        chk("ov_rv_sig", {31'd0, redirect_valid}, 32'h0);
        tick();
        chk("ov_rv", {31'd0, redirect_valid}, 32'h1);
        chk("ov_rpc", redirect_pc, 32'hBFC0_0380);
        chk("ov_type_red", {24'd0, exc_eret_type}, 32'h0);
        chk("ov_flush_red", {31'd0, flush}, 32'h0);
        chk("ov_stall_red", {31'd0, stall}, 32'h1);
        tick();
        idle_outs("ov_done");
        // adel_if in a delay slot
        wb_valid = 1'b1; wb_exc = 7'b1000000; wb_pc = 32'h8000_0002; wb_is_slot = 1'b1;
        tick();
        wb_valid = 1'b0; wb_exc = '0; wb_is_slot = 1'b0;
        chk("adel_type", {24'd0, exc_eret_type}, 32'h40);
        chk("adel_bva", cp0_bad_vaddr, 32'h8000_0002);
        chk("adel_slot", {31'd0, cp0_is_slot}, 32'h1);
        tick(); tick();
        // interrupt together with ERET: int wins, ERET killed
        wb_valid = 1'b1; wb_eret = 1'b1; int_happen = 1'b1; wb_pc = 32'h8000_0040;
        #1;
        chk("int_kill", {31'd0, wb_kill}, 32'h1);
        tick();
        wb_valid = 1'b0; wb_eret = 1'b0; int_happen = 1'b0;
        chk("int_type", {24'd0, exc_eret_type}, 32'h80);
        chk("int_cpc", cp0_pc, 32'h8000_0040);
        chk("int_bva", cp0_bad_vaddr, 32'h0);
        tick();
        chk("int_rpc", redirect_pc, 32'hBFC0_0380);
        tick();
        // ERET only, redirect_ready held low for 3 cycles
        redirect_ready = 1'b0;
        chk("idle_ready_ignored", {31'd0, redirect_valid}, 32'h0);
        cp0_epc = 32'h8000_0100;
        wb_valid = 1'b1; wb_eret = 1'b1; wb_pc = 32'h8000_0300;
        #1;
        chk("eret_kill", {31'd0, wb_kill}, 32'h1);
        tick();
        wb_valid = 1'b0; wb_eret = 1'b0;
        chk("eret_type", {24'd0, exc_eret_type}, 32'h01);
        chk("eret_stall_sig", {31'd0, stall}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("eret_rv_wait", {31'd0, redirect_valid}, 32'h1);
            chk("eret_rpc_wait", redirect_pc, 32'h8000_0100);
            chk("eret_stall_wait", {31'd0, stall}, 32'h1);
        end
        // wb_valid during REDIRECT must not start a new event
        wb_valid = 1'b1; wb_exc = 7'b0001000;
        #1;
        chk("red_kill", {31'd0, wb_kill}, 32'h0);
        tick();
        chk("eret_rv_4", {31'd0, redirect_valid}, 32'h1);
        chk("eret_rpc_4", redirect_pc, 32'h8000_0100);
        wb_valid = 1'b0; wb_exc = '0;
        redirect_ready = 1'b1;
        tick();
        idle_outs("eret_done");
`ifdef EXC_PERF_CNT_EN
        chk("cnt3", exc_count, 32'd3);
`else
        chk("cnt3", exc_count, 32'd0);
`endif
        // ri+sys+ades simultaneously, launched the cycle after a handshake
        wb_valid = 1'b1; wb_exc = 7'b0101001; wb_pc = 32'h8000_0600; wb_daddr = 32'h0000_0ABC;
        tick();
        wb_valid = 1'b0; wb_exc = '0;
        chk("ri_type", {24'd0, exc_eret_type}, 32'h04);
        chk("ri_bva", cp0_bad_vaddr, 32'h0);
        tick();
        tick();
        chk("ri_idle", {31'd0, stall}, 32'h0);
        // back-to-back: ades immediately after return to IDLE
        wb_valid = 1'b1; wb_exc = 7'b0000001; wb_pc = 32'h8000_0700; wb_daddr = 32'h0000_1001;
        tick();
        wb_valid = 1'b0; wb_exc = '0;
        chk("ades_type", {24'd0, exc_eret_type}, 32'h20);
        chk("ades_bva", cp0_bad_vaddr, 32'h0000_1001);
        tick(); tick();
`ifdef EXC_PERF_CNT_EN
        chk("cnt5", exc_count, 32'd5);
`else
        chk("cnt5", exc_count, 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
